// File: rtl/demux_route3_pkg.sv
// Shared definitions for the 1-to-3 stream demultiplexer: channel indices,
// buffer depth and the select-to-channel decode.
package demux_route3_pkg;

  localparam int DEPTH  = 2;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 2;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH1 = 2'd0;
  localparam ch_idx_t CH2 = 2'd1;
  localparam ch_idx_t CH3 = 2'd2;

  // Same select map as the 3:1 mux: 0 and 1 both land on ch1.
  function automatic ch_idx_t sel_to_ch(input logic [1:0] sel);
    case (sel)
      2'd2:    return CH2;
      2'd3:    return CH3;
      default: return CH1;
    endcase
  endfunction

endpackage

// File: rtl/demux_route3_slot.sv
// Two-entry per-channel FIFO: registered count, 1-bit wrapping pointers,
// head and valid derived from registers only.
module demux_route3_slot
  import demux_route3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop_i && (count_q != '0);
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);

endmodule

// File: rtl/demux_route3.sv
// Stream 1-to-3 demultiplexer: decodes the select, gates in_ready on the
// target channel's occupancy and steers beats into three 2-entry slots.
module demux_route3
  import demux_route3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_select,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out3_data,
  output logic             busy
);

  ch_idx_t           ch_idx;
  logic              accept;
  logic              tgt_has_room;
  logic [NUM_CH-1:0] push, pop, valid, ready;
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [WIDTH-1:0]  head  [NUM_CH];

  assign ch_idx = sel_to_ch(in_select);
  assign ready  = {out3_ready, out2_ready, out1_ready};

  // Ready looks only at registered occupancy, never at any sink ready.
  always_comb begin
    tgt_has_room = 1'b0;
    case (ch_idx)
      CH2:     tgt_has_room = (count[1] != CNT_W'(DEPTH));
      CH3:     tgt_has_room = (count[2] != CNT_W'(DEPTH));
      default: tgt_has_room = (count[0] != CNT_W'(DEPTH));
    endcase
  end

  assign in_ready = reset_n && tgt_has_room;
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign push[g] = accept && (ch_idx == ch_idx_t'(g));
    assign pop[g]  = valid[g] && ready[g];

    demux_route3_slot #(.WIDTH(WIDTH)) u_slot (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .data_i  (in_data),
      .count_o (count[g]),
      .head_o  (head[g]),
      .valid_o (valid[g])
    );
  end

  assign out1_valid = valid[0];
  assign out2_valid = valid[1];
  assign out3_valid = valid[2];
  assign out1_data  = head[0];
  assign out2_data  = head[1];
  assign out3_data  = head[2];
  assign busy       = |valid;

endmodule
